// File: rtl/lib_arbiter_pkg.sv
// Shared types, level geometry tables and helpers for the readout-tree arbiters.
package lib_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;

  localparam int NO_LEVELS   = 3;
  localparam int GRP_TIMEOUT = 16;

  // Per-level group geometry; Lvl_ADD holds the local address width for each level.
  localparam int Lvl_ROWS [NO_LEVELS] = '{2, 2, 2};
  localparam int Lvl_COLS [NO_LEVELS] = '{2, 2, 2};
  localparam int Lvl_ADD  [NO_LEVELS] = '{1, 1, 1};

  function automatic int lvl_n(input int lvl);
    return Lvl_ROWS[lvl] * Lvl_COLS[lvl];
  endfunction

endpackage

// File: rtl/group_rr_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod N.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int k;
    k      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Walking offsets from ptr is the rotate / priority-encode / rotate-back in one pass.
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any       = 1'b1;
        idx       = PW'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/group_rr_arbiter.sv
// Round-robin group arbiter for one level of the event-camera readout tree.
// Optional grant watchdog is enabled by defining GRP_ARB_TIMEOUT_EN.
module group_rr_arbiter
  import lib_arbiter_pkg::*;
#(
  parameter int LVL     = 0,
  parameter int G_ROWS  = Lvl_ROWS[LVL],
  parameter int G_COLS  = Lvl_COLS[LVL],
  parameter int N       = G_ROWS * G_COLS,
  parameter int ADD_W   = Lvl_ADD[LVL],
  parameter int TIMEOUT = GRP_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic             up_req_o,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_valid_o,
  output logic [ADD_W-1:0] row_add_o,
  output logic [ADD_W-1:0] col_add_o,
  output logic             timeout_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [ADD_W-1:0] row_q, row_d;
  logic [ADD_W-1:0] col_q, col_d;

  logic [N-1:0]     pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic [PW-1:0]    ptr_after_win;

  rr_priority_pick #(.N(N), .PW(PW)) u_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign ptr_after_win = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);

`ifdef GRP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    row_d   = row_q;
    col_d   = col_q;
`ifdef GRP_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (en_i && pick_any) begin
          gnt_d   = pick_onehot;
          win_d   = pick_idx;
          row_d   = ADD_W'(int'(pick_idx) / G_COLS);
          col_d   = ADD_W'(int'(pick_idx) % G_COLS);
          state_d = ARB_GRANT;
`ifdef GRP_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        // done_i outranks a simultaneous en_i fall so the served child loses priority.
        if (done_i) begin
          gnt_d   = '0;
          ptr_d   = ptr_after_win;
          state_d = ARB_RELEASE;
        end else if (!en_i || !req_i[win_q]) begin
          gnt_d   = '0;
          state_d = ARB_IDLE;
        end
`ifdef GRP_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) begin
            gnt_d   = '0;
            ptr_d   = ptr_after_win;
            tmo_d   = 1'b1;
            state_d = ARB_RELEASE;
          end
        end
`endif
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

`ifdef GRP_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign up_req_o    = |req_i;
  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign row_add_o   = row_q;
  assign col_add_o   = col_q;

endmodule
